set_host: RTL and testbench
===========================

Name: set_host

Overview:
- Initiator side of the SET en/busy/valid job protocol.
- Accepts circle-set jobs (central, radius, mode) from an upstream valid/ready stream and buffers them.
- Issues each job to one SET engine, holds its operands stable, and captures candidate when the job ends.
- Returns a tagged result on a downstream valid/ready stream; sits between the system controller and the SET engine.

Parameters:
- DEPTH, 4, job FIFO entries (power of 2, ≥2).
- TIMEOUT_CYCLES, 255, max cycles from set_en to set_valid before the job is aborted with an error.
- TAG_W, 4, width of the job sequence tag.

Ports:
- clk  in  1  clock
- rst  in  1  async active-high reset
- job_valid  in  1  upstream job present
- job_ready  out  1  FIFO not full
- job_central  in  24  {x1,y1,x2,y2,x3,y3}, 4b each
- job_radius  in  12  {r1,r2,r3}
- job_mode  in  2  0 = A, 1 = A∩B, 2 = A xor B, 3 = exactly two of A,B,C
- set_en  out  1  one-cycle job start pulse to SET
- set_central  out  24  operand to SET
- set_radius  out  12  operand to SET
- set_mode  out  2  operand to SET
- set_busy  in  1  SET busy
- set_valid  in  1  SET result valid
- set_candidate  in  8  SET count
- res_valid  out  1  result available
- res_ready  in  1  downstream accepts
- res_candidate  out  8  captured count (0 on error)
- res_tag  out  TAG_W  sequence number of the job, wraps modulo 2^TAG_W
- res_err  out  1  job timed out

Behaviour:
- Reset (async, any time incl. mid-job):
  - set_en, res_valid, res_err = 0; set_central, set_radius, set_mode, res_candidate, res_tag = 0.
  - FIFO emptied; tag counter = 0; FSM = IDLE.
  - Any in-flight job is discarded; no result is emitted for it.
- FIFO:
  - Write on job_valid&job_ready, stores {central,radius,mode,tag}; tag counter increments per accepted job.
  - job_ready = !full.
  - When full: job_valid is ignored, no overwrite.
  - Simultaneous push/pop when full: pop frees a slot; the push still sees job_ready = 0 that cycle (registered full).
- FSM states:
  - IDLE: if FIFO non-empty and set_busy = 0, pop head into operand regs and go ISSUE. If set_busy = 1, stay (never start onto a busy engine).
  - ISSUE: set_en = 1 for exactly this cycle; timeout counter cleared; go WAIT_BUSY.
  - WAIT_BUSY: wait for set_busy = 1, then go WAIT_VALID. set_valid is ignored here, because a stale valid from the previous job may still be high.
  - WAIT_VALID: on set_busy & set_valid, capture set_candidate into res_candidate, res_err = 0, go DRAIN.
  - DRAIN: wait for set_busy = 0, then go RESULT.
  - RESULT: res_valid = 1, with candidate/tag/err held stable until res_ready. On res_valid & res_ready, go IDLE.
- Operands: set_central/set_radius/set_mode are held constant from ISSUE until leaving DRAIN, because SET samples mode every cycle.
- Timeout:
  - Counter runs in WAIT_BUSY and WAIT_VALID.
  - When it reaches TIMEOUT_CYCLES: res_candidate = 0, res_err = 1, go RESULT (skip DRAIN).
  - IDLE's busy check blocks any new issue while the engine is still busy.
- Latency:
  - Job written at cycle T into an empty FIFO with the FSM idle: pop at T+1, set_en at T+2.
  - res_valid asserts 2 cycles after SET's first busy & valid cycle (capture, DRAIN observes busy low, RESULT).
- Back-pressure: res_ready low stalls the FSM in RESULT; the FIFO keeps accepting until full.
- No combinational path from any input to any output except job_ready (registered full flag).

Decomposition:
- Package set_pkg:
  - typedef set_job_t {central[23:0], radius[11:0], mode[1:0]}.
  - Mode constants MODE_A / MODE_AND / MODE_XOR / MODE_TWO.
  - FSM state enum.
  - GRID_MIN = 1, GRID_MAX = 8.
- Sub-module set_job_fifo: synchronous FIFO with DEPTH, WIDTH params, full/empty flags, async reset.

Test Plan:
- Bench uses a behavioural SET model (busy the cycle after en, 64 scan cycles, valid held until the next en).
- Single job, mode 0, central 0x440000, radius 0x300 -> one set_en pulse; res_candidate = 29, res_tag = 0, res_err = 0.
- Mode 0, central 0x110000, radius 0xF00 -> res_candidate = 64. Then radius 0x000, center (4,4) -> res_candidate = 1. Tags 0, 1 in order.
- Push 6 jobs back-to-back with DEPTH = 4 and res_ready held 0 -> job_ready drops after the 4th FIFO entry. Then set res_ready = 1 -> 6 results in order, tags 0..5, at most one set_en per job, set_en never asserted while set_busy = 1.
- Model never raises valid, TIMEOUT_CYCLES = 20 -> res_err = 1, res_candidate = 0 within 21 cycles of set_en. The next job is not issued until the model drops busy.
- Stale valid: previous job's set_valid still high at the new set_en, with busy asserted the next cycle -> new result equals the new count, not the old one.
- Assert rst mid-WAIT_VALID -> all outputs 0 immediately; FIFO empty; no res_valid for the aborted job; next job gets tag 0.

Source files
------------

// File: rtl/set_pkg.sv
// Shared job type, mode encodings and FSM states for the SET initiator.
package set_pkg;

   localparam int GRID_MIN = 1;
   localparam int GRID_MAX = 8;

   localparam logic [1:0] MODE_A   = 2'd0;
   localparam logic [1:0] MODE_AND = 2'd1;
   localparam logic [1:0] MODE_XOR = 2'd2;
   localparam logic [1:0] MODE_TWO = 2'd3;

   typedef struct packed {
      logic [23:0] central;
      logic [11:0] radius;
      logic [1:0]  mode;
   } set_job_t;

   localparam int JOB_W = $bits(set_job_t);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT_BUSY,
      ST_WAIT_VALID,
      ST_DRAIN,
      ST_RESULT
   } set_state_e;

endpackage

// File: rtl/set_job_fifo.sv
// Small first-word-fall-through job FIFO; full/empty are registered so the
// upstream ready carries no combinational path from any input.
module set_job_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      count_q, count_d;
   logic             full_q, empty_q;
   logic             do_push, do_pop;

   assign do_push = push_i & ~full_q;
   assign do_pop  = pop_i & ~empty_q;

   always_comb begin
      count_d = count_q;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
         full_q  <= (count_d == (AW+1)'(DEPTH));
         empty_q <= (count_d == '0);
      end
   end

   // Storage needs no reset: pointers alone decide what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign full_o  = full_q;
   assign empty_o = empty_q;

endmodule

// File: rtl/set_host.sv
// Initiator for the SET en/busy/valid protocol: buffers jobs, runs them one at
// a time on the engine with a timeout, and returns tagged results.
module set_host
   import set_pkg::*;
#(
   parameter int DEPTH          = 4,
   parameter int TIMEOUT_CYCLES = 255,
   parameter int TAG_W          = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             job_valid,
   output logic             job_ready,
   input  logic [23:0]      job_central,
   input  logic [11:0]      job_radius,
   input  logic [1:0]       job_mode,
   output logic             set_en,
   output logic [23:0]      set_central,
   output logic [11:0]      set_radius,
   output logic [1:0]       set_mode,
   input  logic             set_busy,
   input  logic             set_valid,
   input  logic [7:0]       set_candidate,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [7:0]       res_candidate,
   output logic [TAG_W-1:0] res_tag,
   output logic             res_err
);
   localparam int FW = JOB_W + TAG_W;
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   set_state_e        state_q, state_d;
   set_job_t          in_job, head_job, op_q;
   logic [TAG_W-1:0]  tag_cnt_q, head_tag, tag_q;
   logic [FW-1:0]     fifo_rdata;
   logic [7:0]        cand_q;
   logic              err_q;
   logic [TW-1:0]     tmo_q;
   logic              fifo_full, fifo_empty, push, pop;
   logic              capture, abort, timeout_hit;

   assign in_job    = '{central: job_central, radius: job_radius, mode: job_mode};
   assign push      = job_valid & ~fifo_full;
   assign job_ready = ~fifo_full;

   set_job_fifo #(.DEPTH(DEPTH), .WIDTH(FW)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .wdata_i ({in_job, tag_cnt_q}),
      .pop_i   (pop),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign {head_job, head_tag} = fifo_rdata;
   assign timeout_hit = (tmo_q >= TW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:       if (pop) state_d = ST_ISSUE;
         ST_ISSUE:      state_d = ST_WAIT_BUSY;
         ST_WAIT_BUSY:  if (abort) state_d = ST_RESULT;
                        else if (set_busy) state_d = ST_WAIT_VALID;
         ST_WAIT_VALID: if (capture) state_d = ST_DRAIN;
                        else if (abort) state_d = ST_RESULT;
         ST_DRAIN:      if (!set_busy) state_d = ST_RESULT;
         ST_RESULT:     if (res_ready) state_d = ST_IDLE;
         default:       state_d = ST_IDLE;
      endcase
   end

   // Valid is ignored in WAIT_BUSY: the previous job's valid may still be high.
   always_comb begin
      set_en    = (state_q == ST_ISSUE);
      res_valid = (state_q == ST_RESULT);
      pop       = (state_q == ST_IDLE) && !fifo_empty && !set_busy;
      capture   = (state_q == ST_WAIT_VALID) && set_busy && set_valid;
      abort     = timeout_hit && !capture &&
                  ((state_q == ST_WAIT_BUSY) || (state_q == ST_WAIT_VALID));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tag_cnt_q <= '0;
         tag_q     <= '0;
         op_q      <= '0;
         cand_q    <= '0;
         err_q     <= 1'b0;
         tmo_q     <= '0;
      end else begin
         if (push) tag_cnt_q <= tag_cnt_q + 1'b1;
         if (pop) begin
            op_q  <= head_job;
            tag_q <= head_tag;
         end
         if (state_q == ST_ISSUE)
            tmo_q <= '0;
         else if ((state_q == ST_WAIT_BUSY) || (state_q == ST_WAIT_VALID))
            tmo_q <= tmo_q + 1'b1;
         if (capture) begin
            cand_q <= set_candidate;
            err_q  <= 1'b0;
         end else if (abort) begin
            cand_q <= '0;
            err_q  <= 1'b1;
         end
      end
   end

   assign set_central   = op_q.central;
   assign set_radius    = op_q.radius;
   assign set_mode      = op_q.mode;
   assign res_candidate = cand_q;
   assign res_tag       = tag_q;
   assign res_err       = err_q;

endmodule

// File: tb/tb_set_host.sv
// Directed bench for set_host: behavioural SET engine on the main instance,
// a bench-driven hung engine on a short-timeout second instance.
`timescale 1ns/1ps
module tb_set_host;
   import set_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        job_valid, job_ready;
   logic [23:0] job_central;
   logic [11:0] job_radius;
   logic [1:0]  job_mode;
   logic        set_en, set_busy, set_valid;
   logic [23:0] set_central;
   logic [11:0] set_radius;
   logic [1:0]  set_mode;
   logic [7:0]  set_candidate;
   logic        res_valid, res_ready, res_err;
   logic [7:0]  res_candidate;
   logic [3:0]  res_tag;

   logic        to_job_valid, to_job_ready;
   logic [23:0] to_job_central;
   logic [11:0] to_job_radius;
   logic [1:0]  to_job_mode;
   logic        to_set_en, to_set_busy, to_set_valid;
   logic [23:0] to_set_central;
   logic [11:0] to_set_radius;
   logic [1:0]  to_set_mode;
   logic [7:0]  to_set_candidate;
   logic        to_res_valid, to_res_ready, to_res_err;
   logic [7:0]  to_res_candidate;
   logic [3:0]  to_res_tag;

   set_host dut (
      .clk(clk), .rst(rst),
      .job_valid(job_valid), .job_ready(job_ready), .job_central(job_central),
      .job_radius(job_radius), .job_mode(job_mode),
      .set_en(set_en), .set_central(set_central), .set_radius(set_radius), .set_mode(set_mode),
      .set_busy(set_busy), .set_valid(set_valid), .set_candidate(set_candidate),
      .res_valid(res_valid), .res_ready(res_ready), .res_candidate(res_candidate),
      .res_tag(res_tag), .res_err(res_err)
   );

   set_host #(.TIMEOUT_CYCLES(20)) dut_to (
      .clk(clk), .rst(rst),
      .job_valid(to_job_valid), .job_ready(to_job_ready), .job_central(to_job_central),
      .job_radius(to_job_radius), .job_mode(to_job_mode),
      .set_en(to_set_en), .set_central(to_set_central), .set_radius(to_set_radius),
      .set_mode(to_set_mode), .set_busy(to_set_busy), .set_valid(to_set_valid),
      .set_candidate(to_set_candidate), .res_valid(to_res_valid), .res_ready(to_res_ready),
      .res_candidate(to_res_candidate), .res_tag(to_res_tag), .res_err(to_res_err)
   );

   int n_cmp = 0;
   int n_err = 0;

   // Engine model: counts grid points (1..8 x 1..8) selected by the mode.
   function automatic int set_count(input logic [23:0] c, input logic [11:0] r, input logic [1:0] m);
      int n, dx, dy, hits;
      logic a, b, cc, sel;
      n = 0;
      for (int x = GRID_MIN; x <= GRID_MAX; x++) begin
         for (int y = GRID_MIN; y <= GRID_MAX; y++) begin
            dx = x - int'(c[23:20]); dy = y - int'(c[19:16]);
            a  = (dx*dx + dy*dy) <= int'(r[11:8]) * int'(r[11:8]);
            dx = x - int'(c[15:12]); dy = y - int'(c[11:8]);
            b  = (dx*dx + dy*dy) <= int'(r[7:4]) * int'(r[7:4]);
            dx = x - int'(c[7:4]);   dy = y - int'(c[3:0]);
            cc = (dx*dx + dy*dy) <= int'(r[3:0]) * int'(r[3:0]);
            hits = int'(a) + int'(b) + int'(cc);
            case (m)
               MODE_A:   sel = a;
               MODE_AND: sel = a & b;
               MODE_XOR: sel = a ^ b;
               default:  sel = (hits == 2);
            endcase
            if (sel) n++;
         end
      end
      return n;
   endfunction

   // Busy the cycle after en for 64 cycles; valid rises on the last busy
   // cycle and is held until the next en (one cycle longer when m_stale).
   logic [6:0] m_cnt;
   logic [7:0] m_next;
   bit         m_stale = 1'b0;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         set_busy <= 1'b0; set_valid <= 1'b0; set_candidate <= 8'd0;
         m_cnt <= 7'd0; m_next <= 8'd0;
      end else if (set_en) begin
         set_busy <= 1'b1;
         m_cnt    <= 7'd64;
         m_next   <= 8'(set_count(set_central, set_radius, set_mode));
         if (!m_stale) set_valid <= 1'b0;
      end else begin
         if (m_stale && set_busy && m_cnt == 7'd64) set_valid <= 1'b0;
         if (set_busy) begin
            if (m_cnt != 7'd0) m_cnt <= m_cnt - 7'd1;
            if (m_cnt == 7'd2) begin
               set_valid     <= 1'b1;
               set_candidate <= m_next;
            end
            if (m_cnt <= 7'd1) set_busy <= 1'b0;
         end
      end
   end

   int   en_cnt = 0, viol = 0, to_en_cnt = 0;
   logic en_prev = 1'b0;
   always @(posedge clk) begin
      if (!rst) begin
         if (set_en) en_cnt <= en_cnt + 1;
         if (set_en && (set_busy || en_prev)) viol <= viol + 1;
         if (to_set_en) to_en_cnt <= to_en_cnt + 1;
      end
      en_prev <= set_en;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk); rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic push(input logic [23:0] c, input logic [11:0] r, input logic [1:0] m);
      job_central = c; job_radius = r; job_mode = m; job_valid = 1'b1;
      @(negedge clk);
      job_valid = 1'b0;
   endtask

   task automatic wait_res(input string name, input int cand, input int tag, input int err);
      int k;
      k = 0;
      while (!res_valid && k < 400) begin @(negedge clk); k++; end
      chk({name, "_seen"}, 32'(res_valid), 1);
      if (res_valid) begin
         $display("result %s: cand=%0d tag=%0d err=%0d", name, res_candidate, res_tag, res_err);
         chk({name, "_cand"}, 32'(res_candidate), cand);
         chk({name, "_tag"}, 32'(res_tag), tag);
         chk({name, "_err"}, 32'(res_err), err);
         res_ready = 1'b1;
         @(negedge clk);
         res_ready = 1'b0;
         chk({name, "_drop"}, 32'(res_valid), 0);
      end
   endtask

   task automatic push_when_ready();
      int w;
      w = 0;
      while (!job_ready && w < 2000) begin @(negedge clk); w++; end
      @(negedge clk);
      job_valid = 1'b0;
   endtask

   logic [23:0] tc [6] = '{24'h440000, 24'h110000, 24'h440000, 24'h110000, 24'h114400, 24'h444400};
   logic [11:0] tr [6] = '{12'h300, 12'hF00, 12'h000, 12'h100, 12'hF20, 12'h300};
   logic [1:0]  tm [6] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd2};
   int          te [6] = '{29, 64, 1, 3, 13, 28};

   initial begin
      int lat, k, en_base, viol_base, to_base, ev;
      job_valid = 1'b0; job_central = '0; job_radius = '0; job_mode = '0; res_ready = 1'b0;
      to_job_valid = 1'b0; to_job_central = '0; to_job_radius = '0; to_job_mode = '0;
      to_set_busy = 1'b0; to_set_valid = 1'b0; to_set_candidate = 8'hA5; to_res_ready = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_set_en", 32'(set_en), 0);
      chk("rst_res_valid", 32'(res_valid), 0);
      chk("rst_res_err", 32'(res_err), 0);
      chk("rst_res_tag", 32'(res_tag), 0);
      chk("rst_job_ready", 32'(job_ready), 1);
      rst = 1'b0;
      @(negedge clk);

      // Single job: latency, operands, result and hold under back-pressure
      en_base = en_cnt;
      push(24'h440000, 12'h300, MODE_A);
      chk("lat_pop_no_en", 32'(set_en), 0);
      @(negedge clk);
      chk("lat_en", 32'(set_en), 1);
      chk("op_central", 32'(set_central), 'h440000);
      chk("op_radius", 32'(set_radius), 'h300);
      chk("op_mode", 32'(set_mode), 0);
      lat = 0;
      while (!res_valid && lat < 200) begin @(negedge clk); lat++; end
      chk("lat_res", lat, 66);
      repeat (3) @(negedge clk);
      $display("result single: cand=%0d tag=%0d err=%0d", res_candidate, res_tag, res_err);
      chk("single_hold_valid", 32'(res_valid), 1);
      chk("single_cand", 32'(res_candidate), 29);
      chk("single_tag", 32'(res_tag), 0);
      chk("single_err", 32'(res_err), 0);
      res_ready = 1'b1; @(negedge clk); res_ready = 1'b0;
      chk("single_drop", 32'(res_valid), 0);
      chk("single_en_count", en_cnt - en_base, 1);

      // Full grid and single point, tags in order
      do_reset();
      push(24'h110000, 12'hF00, MODE_A);
      wait_res("full_grid", 64, 0, 0);
      push(24'h440000, 12'h000, MODE_A);
      wait_res("one_point", 1, 1, 0);

      // Six jobs into a 4-deep FIFO with results stalled
      do_reset();
      en_base = en_cnt; viol_base = viol;
      for (int i = 0; i < 6; i++) begin
         job_central = tc[i]; job_radius = tr[i]; job_mode = tm[i]; job_valid = 1'b1;
         chk($sformatf("burst_ready_%0d", i), 32'(job_ready), (i <= 4) ? 1 : 0);
         if (i < 5) @(negedge clk);
      end
      repeat (100) @(negedge clk);
      chk("burst_stall_full", 32'(job_ready), 0);
      chk("burst_stall_valid", 32'(res_valid), 1);
      fork
         push_when_ready();
      join_none
      for (int i = 0; i < 6; i++) wait_res($sformatf("burst_%0d", i), te[i], i, 0);
      chk("burst_en_count", en_cnt - en_base, 6);
      chk("burst_en_violations", viol - viol_base, 0);

      // Stale valid from previous job overlaps the new job's first busy cycle
      do_reset();
      push(24'h110000, 12'hF00, MODE_A);
      wait_res("stale_prev", 64, 0, 0);
      m_stale = 1'b1;
      push(24'h114400, 12'hF30, MODE_TWO);
      wait_res("stale_new", 29, 1, 0);
      m_stale = 1'b0;

      // Timeout on a hung engine (second instance, TIMEOUT_CYCLES = 20)
      do_reset();
      to_job_central = 24'h123456; to_job_radius = 12'h321; to_job_mode = MODE_XOR;
      to_job_valid = 1'b1; @(negedge clk); to_job_valid = 1'b0;
      k = 0;
      while (!to_set_en && k < 10) begin @(negedge clk); k++; end
      chk("to_en_seen", 32'(to_set_en), 1);
      chk("to_op_central", 32'(to_set_central), 'h123456);
      chk("to_op_radius_mode", {18'd0, to_set_radius, to_set_mode}, {18'd0, 12'h321, 2'd2});
      to_set_busy = 1'b1;
      lat = 0;
      while (!to_res_valid && lat < 60) begin @(negedge clk); lat++; end
      $display("result timeout_1: cand=%0d tag=%0d err=%0d", to_res_candidate, to_res_tag, to_res_err);
      chk("to_lat", lat, 21);
      chk("to_err", 32'(to_res_err), 1);
      chk("to_cand", 32'(to_res_candidate), 0);
      chk("to_tag", 32'(to_res_tag), 0);
      to_res_ready = 1'b1; @(negedge clk); to_res_ready = 1'b0;
      to_base = to_en_cnt;
      to_job_valid = 1'b1; @(negedge clk); to_job_valid = 1'b0;
      repeat (15) @(negedge clk);
      chk("to_blocked_by_busy", to_en_cnt - to_base, 0);
      chk("to_ready_while_blocked", 32'(to_job_ready), 1);
      to_set_busy = 1'b0;
      k = 0;
      while (!to_set_en && k < 10) begin @(negedge clk); k++; end
      chk("to_en_after_idle", 32'(to_set_en), 1);
      lat = 0;
      while (!to_res_valid && lat < 60) begin @(negedge clk); lat++; end
      $display("result timeout_2: cand=%0d tag=%0d err=%0d", to_res_candidate, to_res_tag, to_res_err);
      chk("to2_lat", lat, 21);
      chk("to2_err", 32'(to_res_err), 1);
      chk("to2_tag", 32'(to_res_tag), 1);
      to_res_ready = 1'b1; @(negedge clk); to_res_ready = 1'b0;

      // Asynchronous reset in the middle of WAIT_VALID
      do_reset();
      push(24'h440000, 12'h300, MODE_A);
      push(24'h110000, 12'hF00, MODE_A);
      k = 0;
      while (!set_en && k < 10) begin @(negedge clk); k++; end
      chk("mid_en_seen", 32'(set_en), 1);
      repeat (30) @(negedge clk);
      chk("mid_central_before", 32'(set_central), 'h440000);
      #1 rst = 1'b1;
      #1;
      chk("mid_rst_set_en", 32'(set_en), 0);
      chk("mid_rst_central", 32'(set_central), 0);
      chk("mid_rst_radius", 32'(set_radius), 0);
      chk("mid_rst_mode", 32'(set_mode), 0);
      chk("mid_rst_res", {21'd0, res_valid, res_err, res_tag, res_candidate[4:0]}, 0);
      chk("mid_rst_job_ready", 32'(job_ready), 1);
      @(negedge clk); rst = 1'b0;
      en_base = en_cnt; ev = 0;
      for (int i = 0; i < 120; i++) begin
         @(negedge clk);
         if (res_valid) ev++;
      end
      chk("mid_no_result", ev, 0);
      chk("mid_fifo_emptied", en_cnt - en_base, 0);
      push(24'h440000, 12'h000, MODE_A);
      wait_res("after_rst", 1, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
